stage_exe: RTL and testbench
============================

STAGE_EXE -- requirements
Module: stage_exe

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 exe_i_alutype  in  alutype_enum  operation class from regs_idexe (NOP, ARITH, LOGIC, MOVE, SHIFT).
REQ-004 exe_i_aluop  in  aluop_struct  sign flag plus per-class op (mult_op, arith_op, logic_op, move_op, shift_op).
REQ-005 exe_i_src1, exe_i_src2  in  32 each  operands; src1 holds shift amount for SHIFT.
REQ-006 exe_i_rfwa  in  reg_enum;  exe_i_rfwe, exe_i_hilowe, exe_i_dm2rf  in  1 each;  exe_i_memop  in  memop_struct;  exe_i_dmdin  in  32.
REQ-007 exe_o_alures  out  32  ALU result (or effective address for loads/stores).
REQ-008 exe_o_rfwa, exe_o_rfwe, exe_o_dm2rf, exe_o_memop, exe_o_dmdin  out  passthrough of the matching inputs to regs_exemem.
REQ-009 exe_o_hi, exe_o_lo  out  32 each  current HI/LO register contents.
REQ-010 stall_req  out  1  high = hold regs_idexe and earlier stages.

Function
REQ-011 ARITH: ALU_ADD src1+src2 (32-bit wrap); ALU_SUB src1-src2; ALU_LT: {31'b0, src1<src2}, signed compare if aluop.sign else unsigned.
REQ-012 LOGIC: AND/OR/XOR/NOR bitwise. SHIFT: ALU_LL src2<<src1[4:0]; ALU_RL logical right; ALU_RA arithmetic right.
REQ-013 MOVE: ALU_HI -> exe_o_alures = HI; ALU_LO -> LO. ARITH/LOGIC/SHIFT/MOVE results are combinational, same cycle.
REQ-014 Issue: a multi-cycle op starts when FSM is IDLE, alutype==NOP and exe_i_hilowe==1; mult_op selects MULT or DIV. NOP with hilowe==0 is a bubble: no issue, alures=0.
REQ-015 FSM states IDLE, MUL, DIV, DONE. IDLE->MUL on MULT issue; IDLE->DIV on DIV issue with src2!=0; IDLE->DONE on DIV issue with src2==0; MUL/DIV->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-016 Operands latched at issue; signed ops (aluop.sign=1) latch magnitudes and record result signs; later changes on exe_i_src* ignored.
REQ-017 MUL: radix-2 shift-add, one multiplier bit per cycle, 5-bit counter 0..31; 64-bit product.
REQ-018 DIV: restoring, one quotient bit per cycle, 5-bit counter 0..31. Signed: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-019 Divide by zero: LO=32'hFFFF_FFFF, HI=src1 unmodified; completes via DONE in 2 cycles total.
REQ-020 DONE: HI<=product[63:32]/remainder, LO<=product[31:0]/quotient on that edge; values visible on exe_o_hi/lo the next cycle.
REQ-021 stall_req = 1 in the issue cycle and in MUL/DIV; 0 in DONE and IDLE. MULT/DIV occupies stage for 34 cycles, div-by-zero 2.
REQ-022 While stall_req=1: exe_o_rfwe=0, exe_o_dm2rf=0, memop forced to MEM_NONE; no side effects leave the stage.
REQ-023 Any alutype other than NOP is never issued to the FSM; HI/LO change only in DONE.
REQ-024 MOVE reading HI/LO in the cycle after DONE sees the new values (no stale read).

Reset
REQ-025 rst=1 at an edge: FSM->IDLE, counter=0, HI=LO=0, internal operand/product registers=0; stall_req=0 the following cycle.
REQ-026 Reset mid-MUL/DIV aborts the op; HI/LO stay 0; no DONE write occurs.
REQ-027 After rst deasserts, first NOP+hilowe issue starts a fresh op.

Verification
REQ-028 ARITH ADD 32'h7FFF_FFFF+1 -> alures 32'h8000_0000, stall_req 0, rfwe passed through same cycle.
REQ-029 LT signed src1=32'hFFFF_FFFF, src2=1 -> alures 1; unsigned -> 0.
REQ-030 MULT signed -3 x 5 -> stall_req high 33 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1; MFLO next returns 32'hFFFF_FFF1.
REQ-031 DIV signed -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; unsigned 7/2 -> LO=3, HI=1.
REQ-032 DIV src2=0, src1=32'h1234 -> stall_req 1 cycle, HI=32'h1234, LO=32'hFFFF_FFFF.
REQ-033 rst asserted at cycle 10 of MULT -> stall_req 0 next cycle, HI=LO=0, FSM IDLE; subsequent MULT 2x3 gives LO=6.

Source files
------------

// File: rtl/stage_exe_pkg.sv
// ---------------------------------------------------------------------------
// stage_exe_pkg
// Shared types for the execute stage: ALU operation class, per-class
// operation codes, register index and memory-operation descriptor.
// ---------------------------------------------------------------------------
package stage_exe_pkg;

    typedef enum logic [2:0] {
        ALU_NOP   = 3'd0,
        ALU_ARITH = 3'd1,
        ALU_LOGIC = 3'd2,
        ALU_MOVE  = 3'd3,
        ALU_SHIFT = 3'd4
    } alutype_enum;

    typedef enum logic [0:0] {
        ALU_MULT = 1'b0,
        ALU_DIV  = 1'b1
    } mult_op_enum;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_LT  = 2'd2
    } arith_op_enum;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_OR  = 2'd1,
        ALU_XOR = 2'd2,
        ALU_NOR = 2'd3
    } logic_op_enum;

    typedef enum logic [0:0] {
        ALU_HI = 1'b0,
        ALU_LO = 1'b1
    } move_op_enum;

    typedef enum logic [1:0] {
        ALU_LL = 2'd0,
        ALU_RL = 2'd1,
        ALU_RA = 2'd2
    } shift_op_enum;

    typedef struct packed {
        logic         sign;
        mult_op_enum  mult_op;
        arith_op_enum arith_op;
        logic_op_enum logic_op;
        move_op_enum  move_op;
        shift_op_enum shift_op;
    } aluop_struct;

    // Register-file index (r0..r31).
    typedef logic [4:0] reg_enum;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_kind_enum;

    typedef struct packed {
        mem_kind_enum kind;
        logic [1:0]   size;
        logic         sign;
    } memop_struct;

endpackage

// File: rtl/stage_exe_if.sv
// ---------------------------------------------------------------------------
// stage_exe_if
// Bundle between regs_idexe (master side drives exe_i_*), the execute stage
// (slave side drives exe_o_* and stall_req) and regs_exemem.
//   exe_i_*   : decoded operation, operands and passthrough control
//   exe_o_*   : ALU result, HI/LO contents, gated passthrough control
//   stall_req : hold request to regs_idexe and earlier stages
// ---------------------------------------------------------------------------
interface stage_exe_if;
    import stage_exe_pkg::*;

    alutype_enum exe_i_alutype;
    aluop_struct exe_i_aluop;
    logic [31:0] exe_i_src1;
    logic [31:0] exe_i_src2;
    reg_enum     exe_i_rfwa;
    logic        exe_i_rfwe;
    logic        exe_i_hilowe;
    logic        exe_i_dm2rf;
    memop_struct exe_i_memop;
    logic [31:0] exe_i_dmdin;

    logic [31:0] exe_o_alures;
    reg_enum     exe_o_rfwa;
    logic        exe_o_rfwe;
    logic        exe_o_dm2rf;
    memop_struct exe_o_memop;
    logic [31:0] exe_o_dmdin;
    logic [31:0] exe_o_hi;
    logic [31:0] exe_o_lo;
    logic        stall_req;

    modport master (
        output exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwa,
               exe_i_rfwe, exe_i_hilowe, exe_i_dm2rf, exe_i_memop, exe_i_dmdin,
        input  exe_o_alures, exe_o_rfwa, exe_o_rfwe, exe_o_dm2rf, exe_o_memop,
               exe_o_dmdin, exe_o_hi, exe_o_lo, stall_req
    );

    modport slave (
        input  exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwa,
               exe_i_rfwe, exe_i_hilowe, exe_i_dm2rf, exe_i_memop, exe_i_dmdin,
        output exe_o_alures, exe_o_rfwa, exe_o_rfwe, exe_o_dm2rf, exe_o_memop,
               exe_o_dmdin, exe_o_hi, exe_o_lo, stall_req
    );

endinterface

// File: rtl/stage_exe.sv
// ---------------------------------------------------------------------------
// stage_exe
// Execute stage: single-cycle ALU (ARITH/LOGIC/SHIFT/MOVE) plus an iterative
// multiply/divide unit that owns the HI/LO registers.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : stage_exe_if.slave -- operation in, result/passthrough/stall out
// A NOP with hilowe=1 seen while idle issues MULT or DIV. The stage then
// stalls upstream until the op reaches DONE, where HI/LO are written.
// ---------------------------------------------------------------------------
module stage_exe
    import stage_exe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    stage_exe_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam memop_struct MEMOP_NONE = '{kind: MEM_NONE, size: 2'b00, sign: 1'b0};

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // MUL: {partial product high, multiplier/product low}
    // DIV: {partial remainder, dividend/quotient}
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;          // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;            // divide by zero: acc holds final HI/LO
    logic        neg_lo_q, neg_lo_d;    // negate product (MUL) or quotient (DIV)
    logic        neg_hi_q, neg_hi_d;    // negate remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        issue_s;
    logic        stall_s;
    logic        s1_neg_s, s2_neg_s;
    logic [31:0] mag1_s, mag2_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s;
    logic        lt_s;
    logic [31:0] sra_s;
    logic [31:0] alures_s;

    assign issue_s  = (state_q == S_IDLE) && (bus.exe_i_alutype == ALU_NOP) && bus.exe_i_hilowe;
    assign stall_s  = issue_s || (state_q == S_MUL) || (state_q == S_DIV);

    // Operand magnitudes; sign bits only count for signed ops.
    assign s1_neg_s = bus.exe_i_aluop.sign & bus.exe_i_src1[31];
    assign s2_neg_s = bus.exe_i_aluop.sign & bus.exe_i_src2[31];
    assign mag1_s   = s1_neg_s ? (32'd0 - bus.exe_i_src1) : bus.exe_i_src1;
    assign mag2_s   = s2_neg_s ? (32'd0 - bus.exe_i_src2) : bus.exe_i_src2;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole 65-bit value right.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next_s = {mul_sum_s, acc_q[31:1]};

    // Restoring divide: trial-subtract the divisor from the remainder shifted
    // left by one dividend bit; bit 32 set means the trial borrowed.
    assign div_diff_s = acc_q[63:31] - {1'b0, opb_q};
    assign div_next_s = div_diff_s[32] ? {acc_q[62:0], 1'b0}
                                       : {div_diff_s[31:0], acc_q[30:0], 1'b1};

    assign prod_s = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    assign quo_s  = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_s  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    assign lt_s  = bus.exe_i_aluop.sign ? ($signed(bus.exe_i_src1) < $signed(bus.exe_i_src2))
                                        : (bus.exe_i_src1 < bus.exe_i_src2);
    assign sra_s = $signed(bus.exe_i_src2) >>> bus.exe_i_src1[4:0];

    // Single-cycle ALU result selection.
    always_comb begin
        alures_s = 32'd0;
        case (bus.exe_i_alutype)
            ALU_NOP: alures_s = 32'd0;
            ALU_ARITH: begin
                case (bus.exe_i_aluop.arith_op)
                    ALU_ADD: alures_s = bus.exe_i_src1 + bus.exe_i_src2;
                    ALU_SUB: alures_s = bus.exe_i_src1 - bus.exe_i_src2;
                    ALU_LT:  alures_s = {31'd0, lt_s};
                    default: alures_s = 32'd0;
                endcase
            end
            ALU_LOGIC: begin
                case (bus.exe_i_aluop.logic_op)
                    ALU_AND: alures_s = bus.exe_i_src1 & bus.exe_i_src2;
                    ALU_OR:  alures_s = bus.exe_i_src1 | bus.exe_i_src2;
                    ALU_XOR: alures_s = bus.exe_i_src1 ^ bus.exe_i_src2;
                    ALU_NOR: alures_s = ~(bus.exe_i_src1 | bus.exe_i_src2);
                    default: alures_s = 32'd0;
                endcase
            end
            ALU_MOVE: begin
                case (bus.exe_i_aluop.move_op)
                    ALU_HI:  alures_s = hi_q;
                    ALU_LO:  alures_s = lo_q;
                    default: alures_s = 32'd0;
                endcase
            end
            ALU_SHIFT: begin
                case (bus.exe_i_aluop.shift_op)
                    ALU_LL:  alures_s = bus.exe_i_src2 << bus.exe_i_src1[4:0];
                    ALU_RL:  alures_s = bus.exe_i_src2 >> bus.exe_i_src1[4:0];
                    ALU_RA:  alures_s = sra_s;
                    default: alures_s = 32'd0;
                endcase
            end
            default: alures_s = 32'd0;
        endcase
    end

    // Multiply/divide FSM next-state, datapath and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue_s) begin
                    cnt_d = 5'd0;
                    if (bus.exe_i_aluop.mult_op == ALU_MULT) begin
                        state_d  = S_MUL;
                        acc_d    = {32'd0, mag2_s};
                        opb_d    = mag1_s;
                        is_div_d = 1'b0;
                        dz_d     = 1'b0;
                        neg_lo_d = s1_neg_s ^ s2_neg_s;
                        neg_hi_d = 1'b0;
                    end else if (bus.exe_i_src2 == 32'd0) begin
                        // Result is fixed at issue; go straight to DONE.
                        state_d  = S_DONE;
                        acc_d    = {bus.exe_i_src1, 32'hFFFF_FFFF};
                        opb_d    = 32'd0;
                        is_div_d = 1'b1;
                        dz_d     = 1'b1;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                    end else begin
                        state_d  = S_DIV;
                        acc_d    = {32'd0, mag1_s};
                        opb_d    = mag2_s;
                        is_div_d = 1'b1;
                        dz_d     = 1'b0;
                        neg_lo_d = s1_neg_s ^ s2_neg_s;
                        neg_hi_d = s1_neg_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d = mul_next_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                acc_d = div_next_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (dz_q) begin
                    hi_d = acc_q[63:32];
                    lo_d = acc_q[31:0];
                end else if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Side-effecting controls are suppressed while upstream is held.
    assign bus.exe_o_alures = alures_s;
    assign bus.exe_o_rfwa   = bus.exe_i_rfwa;
    assign bus.exe_o_dmdin  = bus.exe_i_dmdin;
    assign bus.exe_o_rfwe   = stall_s ? 1'b0 : bus.exe_i_rfwe;
    assign bus.exe_o_dm2rf  = stall_s ? 1'b0 : bus.exe_i_dm2rf;
    assign bus.exe_o_memop  = stall_s ? MEMOP_NONE : bus.exe_i_memop;
    assign bus.exe_o_hi     = hi_q;
    assign bus.exe_o_lo     = lo_q;
    assign bus.stall_req    = stall_s;

endmodule

// File: tb/tb_stage_exe.sv
// ---------------------------------------------------------------------------
// tb_stage_exe
// Directed stimulus for stage_exe. Each stimulus step pushes the responses
// it expects, stamped with the cycle they must appear in, into a scoreboard
// queue; an independent monitor samples the DUT on the falling edge and
// compares every entry due in that cycle.
// ---------------------------------------------------------------------------
module tb_stage_exe;
    import stage_exe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_exe_if bus();

    stage_exe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        int          sel;    // 0 alures 1 hi 2 lo 3 stall 4 rfwe 5 memop kind 6 dm2rf
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc      = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic        drain    = 1'b0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return bus.exe_o_alures;
            1:       return bus.exe_o_hi;
            2:       return bus.exe_o_lo;
            3:       return {31'd0, bus.stall_req};
            4:       return {31'd0, bus.exe_o_rfwe};
            5:       return {30'd0, bus.exe_o_memop.kind};
            6:       return {31'd0, bus.exe_o_dm2rf};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due this cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                n_tests++;
                act = actual(sb_q[i].sel);
                if (act !== sb_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, want %h (cycle %0d)",
                             sb_q[i].name, act, sb_q[i].val, cyc);
                end
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc || drain) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: never sampled, want %h at cycle %0d",
                         sb_q[i].name, sb_q[i].val, sb_q[i].cyc);
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input string nm, input int sel, input logic [31:0] v, input int c);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.val  = v;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic aluop_struct mkop(input logic sg, input mult_op_enum m,
                                         input arith_op_enum ar, input logic_op_enum lg,
                                         input move_op_enum mv, input shift_op_enum sh);
        aluop_struct o;
        o.sign     = sg;
        o.mult_op  = m;
        o.arith_op = ar;
        o.logic_op = lg;
        o.move_op  = mv;
        o.shift_op = sh;
        return o;
    endfunction

    function automatic aluop_struct op_ar(input logic sg, input arith_op_enum ar);
        return mkop(sg, ALU_MULT, ar, ALU_AND, ALU_HI, ALU_LL);
    endfunction
    function automatic aluop_struct op_lg(input logic_op_enum lg);
        return mkop(1'b0, ALU_MULT, ALU_ADD, lg, ALU_HI, ALU_LL);
    endfunction
    function automatic aluop_struct op_sh(input shift_op_enum sh);
        return mkop(1'b0, ALU_MULT, ALU_ADD, ALU_AND, ALU_HI, sh);
    endfunction
    function automatic aluop_struct op_mv(input move_op_enum mv);
        return mkop(1'b0, ALU_MULT, ALU_ADD, ALU_AND, mv, ALU_LL);
    endfunction
    function automatic aluop_struct op_md(input logic sg, input mult_op_enum m);
        return mkop(sg, m, ALU_ADD, ALU_AND, ALU_HI, ALU_LL);
    endfunction

    task automatic bubble();
        bus.exe_i_alutype = ALU_NOP;
        bus.exe_i_aluop   = op_md(1'b0, ALU_MULT);
        bus.exe_i_src1    = 32'd0;
        bus.exe_i_src2    = 32'd0;
        bus.exe_i_rfwa    = 5'd0;
        bus.exe_i_rfwe    = 1'b0;
        bus.exe_i_hilowe  = 1'b0;
        bus.exe_i_dm2rf   = 1'b0;
        bus.exe_i_memop   = '{kind: MEM_NONE, size: 2'b00, sign: 1'b0};
        bus.exe_i_dmdin   = 32'd0;
    endtask

    task automatic drive(input alutype_enum t, input aluop_struct op,
                         input logic [31:0] a, input logic [31:0] b, input logic hw);
        bus.exe_i_alutype = t;
        bus.exe_i_aluop   = op;
        bus.exe_i_src1    = a;
        bus.exe_i_src2    = b;
        bus.exe_i_rfwa    = 5'd9;
        bus.exe_i_rfwe    = 1'b1;
        bus.exe_i_hilowe  = hw;
        bus.exe_i_dm2rf   = 1'b1;
        bus.exe_i_memop   = '{kind: MEM_STORE, size: 2'b10, sign: 1'b0};
        bus.exe_i_dmdin   = 32'h5555_AAAA;
    endtask

    // Single-cycle op: result, no stall and passthrough in the same cycle.
    task automatic alu_chk(input string nm, input alutype_enum t, input aluop_struct op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v);
        drive(t, op, a, b, 1'b0);
        expect_at(nm, 0, exp_v, cyc);
        expect_at({nm, "_stall"}, 3, 32'd0, cyc);
        expect_at({nm, "_rfwe"}, 4, 32'd1, cyc);
        expect_at({nm, "_memop"}, 5, 32'd2, cyc);
        step();
    endtask

    // Multi-cycle op: stall window, HI/LO timing, then MFLO/MFHI readback.
    task automatic md_chk(input string nm, input logic sg, input mult_op_enum m,
                          input logic [31:0] a, input logic [31:0] b, input logic dz,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c0;
        int n;
        c0 = cyc;
        n  = dz ? 1 : 33;
        drive(ALU_NOP, op_md(sg, m), a, b, 1'b1);
        bus.exe_i_memop.kind = MEM_LOAD;
        expect_at({nm, "_stall_issue"}, 3, 32'd1, c0);
        expect_at({nm, "_rfwe_gated"}, 4, 32'd0, c0);
        expect_at({nm, "_dm2rf_gated"}, 6, 32'd0, c0);
        expect_at({nm, "_memop_gated"}, 5, 32'd0, c0);
        expect_at({nm, "_alures_nop"}, 0, 32'd0, c0);
        if (!dz) begin
            expect_at({nm, "_stall_busy"}, 3, 32'd1, c0 + 1);
            expect_at({nm, "_stall_last"}, 3, 32'd1, c0 + n - 1);
        end
        expect_at({nm, "_stall_done"}, 3, 32'd0, c0 + n);
        expect_at({nm, "_hi_hold"}, 1, model_hi, c0 + n);
        expect_at({nm, "_lo_hold"}, 2, model_lo, c0 + n);
        step();
        if (!dz) begin
            bus.exe_i_src1 = 32'h0BAD_F00D;
            bus.exe_i_src2 = 32'h0000_0007;
        end
        repeat (n) step();
        drive(ALU_MOVE, op_mv(ALU_LO), 32'd0, 32'd0, 1'b0);
        expect_at({nm, "_mflo"}, 0, exp_lo, cyc);
        expect_at({nm, "_hi"}, 1, exp_hi, cyc);
        expect_at({nm, "_lo"}, 2, exp_lo, cyc);
        expect_at({nm, "_stall_after"}, 3, 32'd0, cyc);
        step();
        drive(ALU_MOVE, op_mv(ALU_HI), 32'd0, 32'd0, 1'b0);
        expect_at({nm, "_mfhi"}, 0, exp_hi, cyc);
        step();
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        bubble();
        repeat (3) step();
        rst = 1'b0;
        expect_at("rst_hi", 1, 32'd0, cyc);
        expect_at("rst_lo", 2, 32'd0, cyc);
        expect_at("rst_stall", 3, 32'd0, cyc);
        expect_at("rst_bubble", 0, 32'd0, cyc);
        step();

        alu_chk("add_wrap", ALU_ARITH, op_ar(1'b0, ALU_ADD), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        alu_chk("sub",      ALU_ARITH, op_ar(1'b0, ALU_SUB), 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
        alu_chk("lt_s",     ALU_ARITH, op_ar(1'b1, ALU_LT),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu_chk("lt_u",     ALU_ARITH, op_ar(1'b0, ALU_LT),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_chk("and", ALU_LOGIC, op_lg(ALU_AND), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu_chk("or",  ALU_LOGIC, op_lg(ALU_OR),  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
        alu_chk("xor", ALU_LOGIC, op_lg(ALU_XOR), 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        alu_chk("nor", ALU_LOGIC, op_lg(ALU_NOR), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB);
        alu_chk("sll", ALU_SHIFT, op_sh(ALU_LL), 32'h0000_0004, 32'h8000_00F0, 32'h0000_0F00);
        alu_chk("srl", ALU_SHIFT, op_sh(ALU_RL), 32'h0000_0004, 32'h8000_00F0, 32'h0800_000F);
        alu_chk("sra_mask", ALU_SHIFT, op_sh(ALU_RA), 32'h0000_0024, 32'h8000_00F0, 32'hF800_000F);

        bubble();
        expect_at("bubble_alures", 0, 32'd0, cyc);
        expect_at("bubble_stall", 3, 32'd0, cyc);
        step();

        md_chk("mul_s_m3x5",  1'b1, ALU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        md_chk("mul_u_max",   1'b0, ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        md_chk("div_s_m7d2",  1'b1, ALU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_chk("div_s_7dm2",  1'b1, ALU_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
        md_chk("div_u_7d2",   1'b0, ALU_DIV,  32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0003);
        md_chk("div0_u",      1'b0, ALU_DIV,  32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
        md_chk("div0_s_neg",  1'b1, ALU_DIV,  32'hFFFF_FF00, 32'h0000_0000, 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        // Reset ten cycles into a multiply aborts it with HI/LO cleared.
        c0 = cyc;
        drive(ALU_NOP, op_md(1'b0, ALU_MULT), 32'h0000_0009, 32'h0000_0009, 1'b1);
        repeat (10) step();
        expect_at("abort_stall_busy", 3, 32'd1, cyc);
        rst = 1'b1;
        bubble();
        step();
        rst = 1'b0;
        expect_at("abort_stall", 3, 32'd0, cyc);
        expect_at("abort_hi", 1, 32'd0, cyc);
        expect_at("abort_lo", 2, 32'd0, cyc);
        repeat (40) step();
        expect_at("abort_no_done_hi", 1, 32'd0, cyc);
        expect_at("abort_no_done_lo", 2, 32'd0, cyc);
        step();
        model_hi = 32'd0;
        model_lo = 32'd0;
        if (cyc - c0 < 50) begin
            expect_at("abort_timeline", 3, 32'd1, cyc);
        end

        md_chk("mul_u_2x3", 1'b0, ALU_MULT, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'h0000_0006);

        bubble();
        step();
        step();
        drain = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
